// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA read scheduler.
// Words are 4 bytes, so address bits [1:0] must be zero on a legal range.
package dma_pkg;

    // Scheduler FSM states; also visible on the top's dbg_state port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_e;

    localparam int WORD_BYTES     = 4;
    localparam int ADDR_LSB       = 2;
    localparam int BEAT_W         = 31;
    localparam int DEFAULT_ADDR_W = 32;

endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: combinational round-robin pick over NUM_CH requesters.
// The caller owns the priority pointer; this block only scans from it.
module dma_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] ptr_i,
    output logic [NUM_CH-1:0]         grant_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o,
    output logic                      valid_o
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CW    = IDX_W + 1;
    localparam logic [CW-1:0] WRAP = CW'(NUM_CH);

    logic [CW-1:0] cand;
    logic          found;

    // Scan channels starting at ptr, wrapping at NUM_CH; first requester wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_i} + CW'(i);
            if (cand >= WRAP) begin
                cand = cand - WRAP;
            end
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                     = 1'b1;
                grant_o[cand[IDX_W-1:0]]  = 1'b1;
                idx_o                     = cand[IDX_W-1:0];
            end
        end
    end

    assign valid_o = found;

endmodule

// File: rtl/dma_read_scheduler.sv
// dma_read_scheduler: round-robin front end and sequencer for the DMA read
// engine. Picks a requesting channel, checks its word-aligned address range,
// pulses rd_start, then counts rd_data_valid beats until the range is read.
// Optional: define DMA_SCHED_TIMEOUT_EN to abort a transfer that sees
// TIMEOUT_CYC consecutive cycles without a beat while running.
//
// Engine handshake: rd_start is a single-cycle pulse with rd_start_addr /
// rd_end_addr valid in the same cycle and held until the next launch; the
// engine answers with one rd_data_valid strobe per word and has no
// backpressure, so every strobe seen in RUN is one word delivered.
module dma_read_scheduler
    import dma_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_start_addr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_end_addr,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic                     busy,
    output logic                     rd_start,
    output logic [ADDR_W-1:0]        rd_start_addr,
    output logic [ADDR_W-1:0]        rd_end_addr,
    input  logic                     rd_data_valid,
    output state_e                   dbg_state
);

    localparam int IDX_W = $clog2(NUM_CH);

    // Elaboration-time parameter sanity.
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("dma_read_scheduler: NUM_CH must be 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("dma_read_scheduler: TIMEOUT_CYC must be at least 1");
    end

    state_e                  state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        ch_q;
    logic [BEAT_W-1:0]       beats_q;
    logic [BEAT_W-1:0]       beat_cnt_q;
    logic [NUM_CH-1:0]       ch_grant_q;
    logic [NUM_CH-1:0]       ch_done_q;
    logic [NUM_CH-1:0]       ch_err_q;
    logic                    rd_start_q;
    logic [ADDR_W-1:0]       rd_start_addr_q;
    logic [ADDR_W-1:0]       rd_end_addr_q;

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]         idle_cnt_q;
    logic [TO_W-1:0]         idle_cnt_d;
`endif

    logic [NUM_CH-1:0]       arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_valid;

    logic [ADDR_W-1:0]       sel_start_d;
    logic [ADDR_W-1:0]       sel_end_d;
    logic [BEAT_W-1:0]       beats_d;
    logic                    range_bad_d;
    logic [BEAT_W-1:0]       beat_cnt_d;
    logic [IDX_W-1:0]        ptr_d;
    logic [NUM_CH-1:0]       ch_oh;

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i   (ch_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Address range of the arbitration winner, its word count and legality.
    always_comb begin
        sel_start_d = ch_start_addr[arb_idx*ADDR_W +: ADDR_W];
        sel_end_d   = ch_end_addr[arb_idx*ADDR_W +: ADDR_W];
        beats_d     = BEAT_W'((sel_end_d - sel_start_d) >> ADDR_LSB) + BEAT_W'(1);
        range_bad_d = (sel_start_d[ADDR_LSB-1:0] != '0) ||
                      (sel_end_d[ADDR_LSB-1:0] != '0) ||
                      (sel_end_d < sel_start_d);
    end

    // Beat count after this cycle's strobe, next pointer and one-hot channel.
    always_comb begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        ptr_d      = (ch_q == IDX_W'(NUM_CH - 1)) ? '0 : ch_q + IDX_W'(1);
        ch_oh      = '0;
        ch_oh[ch_q] = 1'b1;
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    // Consecutive beat-less cycles including the current one.
    always_comb begin
        idle_cnt_d = idle_cnt_q + TO_W'(1);
    end
`endif

    // Scheduler FSM with registered pulse outputs and latched transfer data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            ch_q            <= '0;
            beats_q         <= '0;
            beat_cnt_q      <= '0;
            ch_grant_q      <= '0;
            ch_done_q       <= '0;
            ch_err_q        <= '0;
            rd_start_q      <= 1'b0;
            rd_start_addr_q <= '0;
            rd_end_addr_q   <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            idle_cnt_q      <= '0;
`endif
        end else begin
            ch_grant_q <= '0;
            ch_done_q  <= '0;
            ch_err_q   <= '0;
            rd_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        ch_q    <= arb_idx;
                        beats_q <= beats_d;
                        if (range_bad_d) begin
                            ch_err_q <= arb_grant;
                            state_q  <= ERR;
                        end else begin
                            ch_grant_q      <= arb_grant;
                            rd_start_q      <= 1'b1;
                            rd_start_addr_q <= sel_start_d;
                            rd_end_addr_q   <= sel_end_d;
                            state_q         <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    // A strobe coinciding with rd_start is not counted.
                    beat_cnt_q <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
                    idle_cnt_q <= '0;
`endif
                    state_q    <= RUN;
                end
                RUN: begin
                    if (rd_data_valid) begin
                        beat_cnt_q <= beat_cnt_d;
`ifdef DMA_SCHED_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                        if (beat_cnt_d == beats_q) begin
                            ch_done_q <= ch_oh;
                            state_q   <= DONE;
                        end
                    end
`ifdef DMA_SCHED_TIMEOUT_EN
                    else if (idle_cnt_d == TO_W'(TIMEOUT_CYC)) begin
                        ch_err_q <= ch_oh;
                        state_q  <= ERR;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
`endif
                end
                DONE: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                ERR: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ch_grant      = ch_grant_q;
    assign ch_done       = ch_done_q;
    assign ch_err        = ch_err_q;
    assign rd_start      = rd_start_q;
    assign rd_start_addr = rd_start_addr_q;
    assign rd_end_addr   = rd_end_addr_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dma_read_scheduler.sv
// tb_dma_read_scheduler: directed scenarios plus randomized transfers for
// dma_read_scheduler, checked against a transaction-level model of the
// arbitration order, range legality and beat count.
module tb_dma_read_scheduler;
    import dma_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int ADDR_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_start_addr;
    logic [NUM_CH*ADDR_W-1:0] ch_end_addr;
    logic [NUM_CH-1:0]        ch_grant;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH-1:0]        ch_err;
    logic                     busy;
    logic                     rd_start;
    logic [ADDR_W-1:0]        rd_start_addr;
    logic [ADDR_W-1:0]        rd_end_addr;
    logic                     rd_data_valid;
    state_e                   dbg_state;

    dma_read_scheduler #(
        .NUM_CH      (NUM_CH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch_req        (ch_req),
        .ch_start_addr (ch_start_addr),
        .ch_end_addr   (ch_end_addr),
        .ch_grant      (ch_grant),
        .ch_done       (ch_done),
        .ch_err        (ch_err),
        .busy          (busy),
        .rd_start      (rd_start),
        .rd_start_addr (rd_start_addr),
        .rd_end_addr   (rd_end_addr),
        .rd_data_valid (rd_data_valid),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_miss = 0;

    logic [ADDR_W-1:0] st_a [NUM_CH];
    logic [ADDR_W-1:0] en_a [NUM_CH];
    int                ptr_m;
    logic [ADDR_W-1:0] last_sa_m;
    logic [ADDR_W-1:0] last_ea_m;
    // Expected {ch_err, ch_grant} pulse for every launch or rejection.
    logic [2*NUM_CH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] onehot(input int c);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Round-robin reference: first requester at or after ptr_m, wrapping.
    function automatic int pick(input logic [NUM_CH-1:0] m);
        for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (ptr_m + i) % NUM_CH;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    // Pulse monitor: every grant/err pulse must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && ((|ch_grant) || (|ch_err))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {ch_err, ch_grant}, '0);
            end else begin
                check("pulse_seq", {ch_err, ch_grant}, exp_q.pop_front());
            end
        end
        if (rst_n && (rd_start !== (|ch_grant))) begin
            check("rd_start_vs_grant", rd_start, |ch_grant);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addrs();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_start_addr[i*ADDR_W +: ADDR_W] = st_a[i];
            ch_end_addr[i*ADDR_W +: ADDR_W]   = en_a[i];
        end
    endtask

    // Present a request pattern in IDLE and check the launch/reject cycle.
    task automatic issue(input logic [NUM_CH-1:0] mask, output int c, output bit bad,
                         output int beats);
        logic [NUM_CH-1:0] oh;
        check("idle_before_req", busy, 1'b0);
        drive_addrs();
        ch_req        = mask;
        rd_data_valid = 1'($urandom_range(0, 1));
        c     = pick(mask);
        bad   = (st_a[c] % 4 != 0) || (en_a[c] % 4 != 0) || (en_a[c] < st_a[c]);
        beats = bad ? 0 : int'((en_a[c] - st_a[c]) / 4) + 1;
        oh    = onehot(c);
        exp_q.push_back(bad ? {oh, {NUM_CH{1'b0}}} : {{NUM_CH{1'b0}}, oh});
        step();
        check("busy_after_req", busy, 1'b1);
        if (bad) begin
            check("err_pulse", ch_err, oh);
            check("no_grant_on_err", ch_grant, '0);
            check("no_start_on_err", rd_start, 1'b0);
        end else begin
            check("grant_pulse", ch_grant, oh);
            check("rd_start", rd_start, 1'b1);
            check("rd_start_addr", rd_start_addr, st_a[c]);
            check("rd_end_addr", rd_end_addr, en_a[c]);
            check("no_err_on_launch", ch_err, '0);
            last_sa_m = st_a[c];
            last_ea_m = en_a[c];
        end
    endtask

    // Leave the ERR cycle and confirm the block is idle again.
    task automatic finish_err(input int c, input logic [NUM_CH-1:0] hold);
        ch_req        = hold;
        rd_data_valid = 1'($urandom_range(0, 1));
        step();
        check("err_cleared", ch_err, '0);
        check("busy_after_err", busy, 1'b0);
        check("no_start_after_err", rd_start, 1'b0);
        check("addr_held_after_err", rd_start_addr, last_sa_m);
        ptr_m = (c + 1) % NUM_CH;
    endtask

    // From the LAUNCH cycle: feed beats with random gaps and check completion.
    task automatic run_beats(input int c, input int beats, input logic [NUM_CH-1:0] hold,
                             input bit keep);
        ch_req        = keep ? hold : NUM_CH'($urandom);
        rd_data_valid = 1'($urandom_range(0, 1));   // coincides with rd_start: not counted
        step();
        check("start_one_cycle", rd_start, 1'b0);
        for (int b = 0; b < beats; b++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                rd_data_valid = 1'b0;
                ch_req        = keep ? hold : NUM_CH'($urandom);
                step();
                check("no_done_in_gap", ch_done, '0);
                check("busy_in_run", busy, 1'b1);
            end
            rd_data_valid = 1'b1;
            ch_req        = keep ? hold : NUM_CH'($urandom);
            step();
            check("done_after_beat", ch_done, (b == beats - 1) ? onehot(c) : '0);
        end
        check("addr_held_run", rd_end_addr, last_ea_m);
        ch_req        = keep ? hold : '0;
        rd_data_valid = 1'($urandom_range(0, 1));
        step();
        check("done_cleared", ch_done, '0);
        check("busy_after_done", busy, 1'b0);
        ptr_m = (c + 1) % NUM_CH;
    endtask

    task automatic xfer(input logic [NUM_CH-1:0] mask, input bit keep);
        int c;
        bit bad;
        int beats;
        issue(mask, c, bad, beats);
        if (bad) finish_err(c, keep ? mask : '0);
        else     run_beats(c, beats, mask, keep);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, ch_grant, '0);
        check({tag, "_done"}, ch_done, '0);
        check({tag, "_err"}, ch_err, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rd_start"}, rd_start, 1'b0);
        check({tag, "_rd_sa"}, rd_start_addr, '0);
        check({tag, "_rd_ea"}, rd_end_addr, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        bit bad;
        int beats;

        rst_n         = 1'b0;
        ch_req        = '0;
        rd_data_valid = 1'b0;
        ch_start_addr = '0;
        ch_end_addr   = '0;
        ptr_m         = 0;
        last_sa_m     = '0;
        last_ea_m     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            st_a[i] = '0;
            en_a[i] = '0;
        end
        step();
        step();
        check_all_zero("reset");
        check("reset_state", dbg_state, IDLE);
        rst_n = 1'b1;
        step();
        check_all_zero("post_reset_idle");

        // Round-robin between ch0 and ch2, both holding their requests.
        st_a[0] = 32'h20;  en_a[0] = 32'h20;
        st_a[2] = 32'h80;  en_a[2] = 32'h80;
        st_a[3] = 32'h300; en_a[3] = 32'h300;
        for (int k = 0; k < 4; k++) xfer(4'b0101, 1'b1);
        xfer(4'b1000, 1'b0);

        // Single four-word transfer on ch0.
        st_a[0] = 32'h100; en_a[0] = 32'h10C;
        xfer(4'b0001, 1'b0);

        // Rejections on ch1: misaligned start, then end below start.
        st_a[1] = 32'h102; en_a[1] = 32'h110;
        xfer(4'b0010, 1'b0);
        st_a[1] = 32'h200; en_a[1] = 32'h1FC;
        xfer(4'b0010, 1'b0);
        st_a[1] = 32'h200; en_a[1] = 32'h20E;
        xfer(4'b0010, 1'b0);

        // Single word with requests toggling while running.
        st_a[1] = 32'h40; en_a[1] = 32'h40;
        xfer(4'b0010, 1'b0);

`ifdef DMA_SCHED_TIMEOUT_EN
        // One beat then silence: abort after TIMEOUT_CYC idle cycles.
        st_a[1] = 32'h400; en_a[1] = 32'h40C;
        issue(4'b0010, c, bad, beats);
        ch_req = '0;
        rd_data_valid = 1'b0;
        step();
        rd_data_valid = 1'b1;
        step();
        rd_data_valid = 1'b0;
        exp_q.push_back({onehot(c), {NUM_CH{1'b0}}});
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            step();
            check("no_timeout_yet", ch_err, '0);
        end
        step();
        check("timeout_err", ch_err, onehot(c));
        check("timeout_busy", busy, 1'b1);
        rd_data_valid = 1'b1;
        step();
        check("late_beat_no_done", ch_done, '0);
        check("timeout_idle", busy, 1'b0);
        step();
        check("late_beat2_no_done", ch_done, '0);
        rd_data_valid = 1'b0;
        ptr_m = (c + 1) % NUM_CH;
`else
        // One beat, a long silence, then the rest: no abort, normal done.
        st_a[1] = 32'h400; en_a[1] = 32'h404;
        issue(4'b0010, c, bad, beats);
        ch_req = '0;
        rd_data_valid = 1'b0;
        step();
        rd_data_valid = 1'b1;
        step();
        rd_data_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            check("wait_no_err", ch_err, '0);
        end
        check("wait_busy", busy, 1'b1);
        rd_data_valid = 1'b1;
        step();
        check("done_after_wait", ch_done, onehot(c));
        rd_data_valid = 1'b0;
        step();
        check("idle_after_wait", busy, 1'b0);
        ptr_m = (c + 1) % NUM_CH;
`endif

        // Reset in the middle of an eight-word transfer on ch2.
        st_a[2] = 32'h1000; en_a[2] = 32'h101C;
        issue(4'b0100, c, bad, beats);
        ch_req = '0;
        rd_data_valid = 1'b0;
        step();
        rd_data_valid = 1'b1;
        step();
        step();
        rd_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        ch_req = '1;
        rd_data_valid = 1'b1;
        step();
        check_all_zero("held_reset");
        ptr_m     = 0;
        last_sa_m = '0;
        last_ea_m = '0;
        ch_req    = '0;
        rst_n     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rd_data_valid = 1'($urandom_range(0, 1));
            step();
            check("after_reset_done", ch_done, '0);
            check("after_reset_err", ch_err, '0);
            check("after_reset_busy", busy, 1'b0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            st_a[i] = 32'h500 + 32'(i * 16);
            en_a[i] = st_a[i];
        end
        xfer(4'b1111, 1'b0);

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            logic [NUM_CH-1:0] mask;
            mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            for (int i = 0; i < NUM_CH; i++) begin
                int r;
                logic [ADDR_W-1:0] base;
                base = 32'($urandom_range(16, 1023) * 4);
                st_a[i] = base;
                en_a[i] = base + 32'($urandom_range(0, 7) * 4);
                r = $urandom_range(0, 9);
                if (r == 0) st_a[i] = st_a[i] | 32'($urandom_range(1, 3));
                if (r == 1) en_a[i] = en_a[i] | 32'($urandom_range(1, 3));
                if (r == 2) en_a[i] = base - 32'($urandom_range(1, 4) * 4);
            end
            xfer(mask, 1'($urandom_range(0, 1)));
        end

        ch_req = '0;
        rd_data_valid = 1'b0;
        step();
        step();
        check("final_idle", busy, 1'b0);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
